// File: rtl/uart_bus_bridge.sv
// Memory-mapped CPU bus bridge to a byte UART: TX FIFO with kick/handshake FSM,
// single-byte RX buffer with overrun detection, control/status register and interrupt.
module uart_bus_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018,
  parameter int          TX_DEPTH     = 4,
  parameter int          BUSY_TIMEOUT = 1023
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_enable,
  input  logic        uart_tx_status,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_status
);

  localparam int          PW        = $clog2(TX_DEPTH);
  localparam int          TW        = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [31:0] RXD_ADDR  = BASE_ADDR + 32'd4;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {IDLE, KICK, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_reg;
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [TW-1:0] timer_reg;
  logic [7:0]    rx_buf_reg;
  logic          rx_valid_reg;
  logic          rx_overrun_reg;
  logic          tx_drop_reg;
  logic          rx_irq_en_reg;
  logic          tx_irq_en_reg;
  logic          rx_status_reg;

  logic hit_txd, hit_rxd, hit_ctrl;
  logic push_req, push, pop, drop;
  logic rd_rxd, wr_ctrl, capture;
  logic fifo_empty, fifo_full, tx_busy;
  logic [7:0] ctrl_bits;
  logic unused_wdata;

  assign hit_txd    = (addr == BASE_ADDR);
  assign hit_rxd    = (addr == RXD_ADDR);
  assign hit_ctrl   = (addr == CTRL_ADDR);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (PW+1)'(TX_DEPTH));
  assign tx_busy    = (state_reg != IDLE);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_req = mem_write & hit_txd & ~reset;
  assign pop      = (state_reg == IDLE) & ~fifo_empty & uart_tx_status;
  assign push     = push_req & (~fifo_full | pop);
  assign drop     = push_req & ~push;

  assign rd_rxd   = mem_read & hit_rxd;
  assign wr_ctrl  = mem_write & hit_ctrl;
  assign capture  = uart_rx_status & ~rx_status_reg;

  assign ctrl_bits = {tx_drop_reg, rx_overrun_reg, tx_busy, fifo_full,
                      fifo_empty, rx_valid_reg, tx_irq_en_reg, rx_irq_en_reg};
  assign unused_wdata = ^{wdata[31:8], wdata[5:2]};

  always_comb begin
    rdata = '0;
    if (hit_rxd)
      rdata = {24'b0, rx_buf_reg};
    else if (hit_ctrl)
      rdata = {24'b0, ctrl_bits};
  end

  always_ff @(posedge sysclk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= wdata[7:0];
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Enable is registered on the load so it is high exactly while in KICK.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_reg      <= IDLE;
      uart_tx_data   <= '0;
      uart_tx_enable <= 1'b0;
      timer_reg      <= '0;
    end else begin
      uart_tx_enable <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            uart_tx_data   <= fifo_mem[rd_ptr_reg];
            uart_tx_enable <= 1'b1;
            state_reg      <= KICK;
          end
        end
        KICK: begin
          timer_reg <= '0;
          state_reg <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!uart_tx_status)
            state_reg <= WAIT_DONE;
          else if (timer_reg == TW'(BUSY_TIMEOUT - 1))
            state_reg <= IDLE;
          else
            timer_reg <= timer_reg + TW'(1);
        end
        WAIT_DONE: begin
          if (uart_tx_status)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Hardware sets of sticky flags take priority over software clears.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_status_reg  <= 1'b0;
      rx_buf_reg     <= '0;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
      tx_drop_reg    <= 1'b0;
      rx_irq_en_reg  <= 1'b0;
      tx_irq_en_reg  <= 1'b0;
      irq            <= 1'b0;
    end else begin
      rx_status_reg <= uart_rx_status;
      if (capture) begin
        rx_buf_reg   <= uart_rx_data;
        rx_valid_reg <= 1'b1;
      end else if (rd_rxd) begin
        rx_valid_reg <= 1'b0;
      end
      if (capture & rx_valid_reg & ~rd_rxd)
        rx_overrun_reg <= 1'b1;
      else if (wr_ctrl & wdata[6])
        rx_overrun_reg <= 1'b0;
      if (drop)
        tx_drop_reg <= 1'b1;
      else if (wr_ctrl & wdata[7])
        tx_drop_reg <= 1'b0;
      if (wr_ctrl) begin
        rx_irq_en_reg <= wdata[0];
        tx_irq_en_reg <= wdata[1];
      end
      irq <= (rx_irq_en_reg & rx_valid_reg) | (tx_irq_en_reg & fifo_empty & ~tx_busy);
    end
  end

endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0018: byte address of the TXD register; RXD is at BASE_ADDR+4 and CTRL at BASE_ADDR+8.
REQ-002 Parameter TX_DEPTH, default 4: TX FIFO entries, a power of 2 and at least 2.
REQ-003 Parameter BUSY_TIMEOUT, default 1023: maximum sysclk cycles to wait for the UART to drop tx_status after a kick.
REQ-004 Clocking and reset SHALL be one clock, sysclk; reset is synchronous and active-high.
REQ-005 Port list (name  direction  width  meaning):
- sysclk  in  1  system clock; all logic on the posedge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  CPU bus byte address.
- wdata  in  32  CPU write data.
- mem_read  in  1  read strobe.
- mem_write  in  1  write strobe.
- rdata  out  32  read data; combinational from addr; 0 when no register is hit.
- irq  out  1  registered interrupt request.
- uart_tx_data  out  8  byte presented to the UART transmitter.
- uart_tx_enable  out  1  one-cycle kick to the UART transmitter.
- uart_tx_status  in  1  1 = transmitter idle.
- uart_rx_data  in  8  received byte.
- uart_rx_status  in  1  high for many sysclk cycles when a byte is ready.

Function
REQ-006 A write to TXD SHALL push wdata[7:0] into the TX FIFO; if the FIFO is full and no pop occurs that cycle, the byte SHALL be dropped and sticky tx_drop set.
REQ-007 The TX FSM states SHALL be IDLE, KICK, WAIT_BUSY and WAIT_DONE.
REQ-008 IDLE with the FIFO non-empty and uart_tx_status=1: load the FIFO head into uart_tx_data, pop it, and go to KICK.
REQ-009 KICK SHALL assert uart_tx_enable for exactly one cycle, then go to WAIT_BUSY.
REQ-010 WAIT_BUSY SHALL go to WAIT_DONE when uart_tx_status=0, and to IDLE after BUSY_TIMEOUT cycles with no drop of uart_tx_status.
REQ-011 WAIT_DONE SHALL go to IDLE when uart_tx_status=1.
REQ-012 tx_busy SHALL equal (state != IDLE).
REQ-013 uart_tx_data SHALL be held stable from KICK until the next load.
REQ-014 A push and a pop in the same cycle SHALL both take effect: count unchanged, and a full FIFO accepts the push.
REQ-015 The FIFO count width SHALL be log2(TX_DEPTH)+1 bits; read and write pointers wrap modulo TX_DEPTH.
REQ-016 uart_rx_status SHALL be registered and rising-edge detected, giving exactly one capture per high period.
REQ-017 On a capture, uart_rx_data SHALL be latched into rx_buf and rx_valid set; if rx_valid was already 1, sticky rx_overrun SHALL be set and rx_buf overwritten.
REQ-018 Each cycle mem_read=1 with addr=RXD, rdata SHALL be {24'b0, rx_buf} and rx_valid SHALL clear at the clock edge.
REQ-019 If a capture and an RXD read coincide, the capture SHALL win: rx_valid stays 1, rx_buf takes the new byte, and rx_overrun is not set.
REQ-020 CTRL read SHALL return {24'b0, tx_drop, rx_overrun, tx_busy, fifo_full, fifo_empty, rx_valid, tx_irq_en, rx_irq_en} (bit 7 down to bit 0).
REQ-021 A CTRL write SHALL load bits[1:0] into the enables; writing 1 to bit 6 or bit 7 SHALL clear that sticky flag.
REQ-022 If a hardware set and a W1C clear of the same sticky flag coincide, the set SHALL win.
REQ-023 A TXD read SHALL return 0.
REQ-024 irq SHALL be registered, one cycle after its inputs: irq <= (rx_irq_en & rx_valid) | (tx_irq_en & fifo_empty & ~tx_busy).
REQ-025 mem_read and mem_write asserted together SHALL perform both the write and the read side effects.

Reset
REQ-026 reset=1 SHALL force state=IDLE, clear the FIFO (empty, pointers 0), and zero uart_tx_data, uart_tx_enable, irq, rx_buf, rx_valid, rx_overrun, tx_drop, rx_irq_en, tx_irq_en and the edge-detect register.
REQ-027 Reset mid-transmission SHALL abandon the FSM without another kick; the UART is not reset by this block.
REQ-028 Bus strobes during reset SHALL be ignored.

Verification
REQ-029 Write TXD=0x41, UART model idle -> one uart_tx_enable pulse exactly 2 cycles after the write with uart_tx_data=0x41; tx_busy=1 until uart_tx_status returns to 1.
REQ-030 With uart_tx_status=0, write 5 bytes 0x01..0x05 (TX_DEPTH=4) -> fifo_full=1, tx_drop=1, CTRL=0x90; release the UART -> 0x01..0x04 sent in order, 0x05 never sent.
REQ-031 uart_rx_status high for 163 cycles with data 0x5A -> exactly one capture, rx_valid=1; RXD read returns 0x5A and rx_valid=0 the next cycle.
REQ-032 Two RX bytes 0x11 then 0x22 with no read -> rx_overrun=1, RXD=0x22; write CTRL=0x40 -> rx_overrun=0.
REQ-033 CTRL=0x03, FIFO empty, idle -> irq=1 one cycle later; write TXD -> irq=0 while tx_busy=1.
REQ-034 UART never drops tx_status after a kick -> return to IDLE after 1023 cycles, and the next FIFO byte is kicked.
